// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: default widths, memory timeout and MDR handshake states.
package cpu_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned MEM_TIMEOUT    = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } mdr_state_t;

endpackage

// File: rtl/mdr_wait_timer.sv
// 8-bit wait-state counter with synchronous clear/increment and terminal-count decode.
module mdr_wait_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic clr,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_terminal
);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_inc) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_terminal = (r_count == 8'(LIMIT - 1));

endmodule

// File: rtl/mdr_mem_if.sv
// Memory Data Register with a read/write handshake FSM that stalls on wait states and times out.
module mdr_mem_if #(
    parameter int unsigned DATA_WIDTH     = cpu_pkg::DATA_WIDTH_DEF,
    parameter int unsigned TIMEOUT_CYCLES = cpu_pkg::MEM_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] BusMuxOut,
    input  logic [DATA_WIDTH-1:0] Mdatain,
    input  logic                  Read,
    input  logic                  MDRin,
    input  logic                  start_rd,
    input  logic                  start_wr,
    input  logic                  mem_ack,
    output logic [DATA_WIDTH-1:0] Q,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    import cpu_pkg::*;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 2..255");
    end

    mdr_state_t            r_state;
    mdr_state_t            w_state_next;
    logic [DATA_WIDTH-1:0] r_q;
    logic                  r_err;
    logic                  w_in_wait;
    logic                  w_tmr_term;
    logic                  w_start;

    assign w_in_wait = (r_state == RD_WAIT) || (r_state == WR_WAIT);
    assign w_start   = (r_state == IDLE) && (start_rd || start_wr);

    // Held clear outside the WAIT states, so every WAIT entry starts from zero.
    mdr_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .clr        (clr),
        .i_clear    (!w_in_wait),
        .i_inc      (w_in_wait),
        .o_terminal (w_tmr_term)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start_rd) begin
                    w_state_next = RD_WAIT;
                end else if (start_wr) begin
                    w_state_next = WR_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (mem_ack || w_tmr_term) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_rd    = (r_state == RD_WAIT);
        mem_wr    = (r_state == WR_WAIT);
        busy      = w_in_wait;
        done      = (r_state == DONE);
        mem_wdata = (r_state == WR_WAIT) ? r_q : '0;
    end

    // A start request in IDLE pre-empts a direct load in the same cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_q <= '0;
        end else if ((r_state == IDLE) && !start_rd && !start_wr && MDRin) begin
            r_q <= Read ? Mdatain : BusMuxOut;
        end else if ((r_state == RD_WAIT) && mem_ack) begin
            r_q <= Mdatain;
        end
    end

    // Ack wins over a simultaneous terminal count.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_err <= 1'b0;
        end else if (w_start) begin
            r_err <= 1'b0;
        end else if (w_in_wait) begin
            if (mem_ack) begin
                r_err <= 1'b0;
            end else if (w_tmr_term) begin
                r_err <= 1'b1;
            end
        end
    end

    assign Q   = r_q;
    assign err = r_err;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Self-checking bench for mdr_mem_if: directed handshake sequences with a completion scoreboard.
module tb_mdr_mem_if;

    localparam int unsigned DW = 32;
    localparam int unsigned TO = 4;

    logic          clk;
    logic          clr;
    logic [DW-1:0] BusMuxOut;
    logic [DW-1:0] Mdatain;
    logic          Read;
    logic          MDRin;
    logic          start_rd;
    logic          start_wr;
    logic          mem_ack;
    logic [DW-1:0] Q;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic          busy;
    logic          done;
    logic          err;

    typedef struct {
        logic [DW-1:0] q;
        logic          err;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mdr_mem_if #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .BusMuxOut (BusMuxOut),
        .Mdatain   (Mdatain),
        .Read      (Read),
        .MDRin     (MDRin),
        .start_rd  (start_rd),
        .start_wr  (start_wr),
        .mem_ack   (mem_ack),
        .Q         (Q),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [DW-1:0] q, input logic e);
        exp_t x;
        x.q   = q;
        x.err = e;
        sb.push_back(x);
    endtask

    // Completion monitor: each done pulse retires one scoreboard entry.
    always @(negedge clk) begin
        if (!clr && done) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                check_eq("done_q", 64'(Q), 64'(x.q));
                check_eq("done_err", 64'(err), 64'(x.err));
            end
        end
    end

    initial begin
        int cnt;
        clr = 1'b1;
        BusMuxOut = '0;
        Mdatain = '0;
        Read = 1'b0;
        MDRin = 1'b0;
        start_rd = 1'b0;
        start_wr = 1'b0;
        mem_ack = 1'b0;
        tick();
        tick();
        check_eq("rst_q", 64'(Q), 64'd0);
        check_eq("rst_strobes", {60'd0, mem_rd, mem_wr, busy, done}, 64'd0);
        check_eq("rst_err_wdata", {31'd0, err, mem_wdata}, 64'd0);

        // Direct load from the bus, then asynchronous clear mid-cycle.
        clr = 1'b0;
        MDRin = 1'b1;
        Read = 1'b0;
        BusMuxOut = 32'hDEADBEEF;
        tick();
        MDRin = 1'b0;
        check_eq("load_bus_q", 64'(Q), 64'hDEADBEEF);
        check_eq("load_bus_done", 64'(done), 64'd0);
        #2 clr = 1'b1;
        #1 check_eq("async_clr_q", 64'(Q), 64'd0);
        tick();
        clr = 1'b0;

        // Read with ack on the third wait cycle.
        start_rd = 1'b1;
        Mdatain = 32'h12345678;
        push_exp(32'h12345678, 1'b0);
        tick();
        start_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("rd3_mem_rd", 64'(mem_rd), 64'd1);
            check_eq("rd3_busy", 64'(busy), 64'd1);
            if (i == 2) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check_eq("rd3_done", 64'(done), 64'd1);
        check_eq("rd3_rd_drop", 64'(mem_rd), 64'd0);
        tick();
        check_eq("rd3_done_once", 64'(done), 64'd0);

        // Load via Mdatain, then write with ack after one cycle.
        MDRin = 1'b1;
        Read = 1'b1;
        Mdatain = 32'hA5A5A5A5;
        tick();
        MDRin = 1'b0;
        check_eq("load_mem_q", 64'(Q), 64'hA5A5A5A5);
        start_wr = 1'b1;
        push_exp(32'hA5A5A5A5, 1'b0);
        tick();
        start_wr = 1'b0;
        BusMuxOut = 32'h0;
        Mdatain = 32'hFFFFFFFF;
        check_eq("wr_mem_wr", 64'(mem_wr), 64'd1);
        check_eq("wr_mem_rd", 64'(mem_rd), 64'd0);
        check_eq("wr_wdata", 64'(mem_wdata), 64'hA5A5A5A5);
        tick();
        check_eq("wr_wdata2", 64'(mem_wdata), 64'hA5A5A5A5);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("wr_done", 64'(done), 64'd1);
        check_eq("wr_wdata_idle", 64'(mem_wdata), 64'd0);
        check_eq("wr_q_hold", 64'(Q), 64'hA5A5A5A5);
        tick();

        // Timeout: no ack at all.
        start_rd = 1'b1;
        Mdatain = 32'h11112222;
        push_exp(32'hA5A5A5A5, 1'b1);
        tick();
        start_rd = 1'b0;
        cnt = 0;
        for (int g = 0; g < 20 && mem_rd; g++) begin
            cnt++;
            tick();
        end
        check_eq("to_rd_cycles", 64'(cnt), 64'(TO));
        check_eq("to_done", 64'(done), 64'd1);
        check_eq("to_err", 64'(err), 64'd1);
        tick();
        check_eq("to_err_held", 64'(err), 64'd1);

        // Ack on the last allowed cycle wins over the timeout.
        start_rd = 1'b1;
        Mdatain = 32'hCAFEF00D;
        push_exp(32'hCAFEF00D, 1'b0);
        tick();
        start_rd = 1'b0;
        check_eq("start_clears_err", 64'(err), 64'd0);
        for (int i = 0; i < int'(TO); i++) begin
            if (i == int'(TO) - 1) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check_eq("edge_ack_done", 64'(done), 64'd1);
        tick();

        // All requests together: read taken, no direct load; later requests ignored.
        MDRin = 1'b1;
        Read = 1'b0;
        BusMuxOut = 32'h55555555;
        start_rd = 1'b1;
        start_wr = 1'b1;
        Mdatain = 32'h77778888;
        push_exp(32'h77778888, 1'b0);
        tick();
        MDRin = 1'b0;
        start_rd = 1'b0;
        start_wr = 1'b0;
        check_eq("simul_mem_rd", 64'(mem_rd), 64'd1);
        check_eq("simul_mem_wr", 64'(mem_wr), 64'd0);
        check_eq("simul_no_load", 64'(Q), 64'hCAFEF00D);
        MDRin = 1'b1;
        start_wr = 1'b1;
        BusMuxOut = 32'h99999999;
        tick();
        MDRin = 1'b0;
        start_wr = 1'b0;
        check_eq("wait_ignore_q", 64'(Q), 64'hCAFEF00D);
        check_eq("wait_still_rd", 64'(mem_rd), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("simul_done", 64'(done), 64'd1);
        tick();
        check_eq("no_queued_wr", 64'(mem_wr), 64'd0);
        tick();
        check_eq("no_queued_wr2", {62'd0, mem_wr, busy}, 64'd0);

        // Clear during a read: strobe drops at once and no done pulse.
        start_rd = 1'b1;
        Mdatain = 32'h0BADF00D;
        tick();
        start_rd = 1'b0;
        tick();
        check_eq("mid_rd_active", 64'(mem_rd), 64'd1);
        #2 clr = 1'b1;
        #1;
        check_eq("mid_clr_strobes", {61'd0, mem_rd, busy, done}, 64'd0);
        check_eq("mid_clr_q", 64'(Q), 64'd0);
        tick();
        clr = 1'b0;
        tick();
        check_eq("mid_clr_no_done", 64'(done), 64'd0);
        start_rd = 1'b1;
        Mdatain = 32'h13579BDF;
        push_exp(32'h13579BDF, 1'b0);
        tick();
        start_rd = 1'b0;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("after_clr_done", 64'(done), 64'd1);
        tick();
        tick();
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdr_mem_if.md
Name: mdr_mem_if

Overview:
- Memory Data Register with a memory read/write handshake for the CPU datapath.
- Sits between the memory port and the internal bus. It captures bus data or memory data, and its Q drives the bus mux that feeds the general-purpose registers (R0..R15).
- Adds a small handshake FSM so that memory reads and writes with variable latency stall cleanly and time out instead of hanging.

Parameters:
- DATA_WIDTH, 32, width of the MDR and of the memory data paths.
- TIMEOUT_CYCLES, 16, maximum wait-state cycles without mem_ack before aborting. Legal range is 2..255.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- clr  input  1  asynchronous, active-high reset.
- BusMuxOut  input  DATA_WIDTH  internal bus value.
- Mdatain  input  DATA_WIDTH  read data from memory.
- Read  input  1  direct-load source select: 1 selects Mdatain, 0 selects BusMuxOut.
- MDRin  input  1  direct-load enable, honoured in IDLE only.
- start_rd  input  1  request a memory read into the MDR; 1-cycle pulse, IDLE only.
- start_wr  input  1  request a memory write of Q; 1-cycle pulse, IDLE only.
- mem_ack  input  1  memory acknowledge; read data is valid with it.
- Q  output  DATA_WIDTH  MDR contents to the bus mux.
- mem_rd  output  1  registered read strobe.
- mem_wr  output  1  registered write strobe.
- mem_wdata  output  DATA_WIDTH  write data; equals Q while mem_wr is 1, 0 otherwise.
- busy  output  1  high in RD_WAIT and WR_WAIT.
- done  output  1  1-cycle completion pulse.
- err  output  1  timeout flag; qualified by done.

Behaviour:
- Reset:
  - Asynchronous, active-high clr.
  - While clr=1: Q=0, state=IDLE, timer=0, and mem_rd, mem_wr, mem_wdata, busy, done, err are all 0.
  - clr mid-transaction aborts immediately with no done pulse. Memory must tolerate a dropped strobe.
- The FSM has four states: IDLE, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - start_rd=1 goes to RD_WAIT with timer=0.
  - Otherwise start_wr=1 goes to WR_WAIT with timer=0; start_rd has priority.
  - Otherwise MDRin=1 loads Q from Mdatain if Read=1, else from BusMuxOut.
  - A start request in the same cycle as MDRin wins, and MDRin is ignored.
- RD_WAIT:
  - mem_rd=1 and busy=1.
  - On mem_ack=1: Q<=Mdatain, err<=0, go to DONE.
  - Else, if timer==TIMEOUT_CYCLES-1: err<=1, Q unchanged, go to DONE.
  - Else timer<=timer+1.
- WR_WAIT:
  - mem_wr=1, mem_wdata=Q, busy=1.
  - mem_ack=1 goes to DONE with err=0; timeout behaves as in RD_WAIT.
  - Q is held constant throughout.
- DONE:
  - done=1 for exactly one cycle; err holds the result; then go to IDLE.
  - start_rd, start_wr and MDRin are ignored in DONE.
- Ignored inputs:
  - start_rd, start_wr and MDRin are ignored in every non-IDLE state. There is no queueing.
  - mem_ack outside the WAIT states is ignored.
- Latency:
  - mem_rd/mem_wr rise 1 cycle after the start pulse.
  - With mem_ack in the first WAIT cycle, Q is updated and done=1 two cycles after start.
  - Worst case: done arrives TIMEOUT_CYCLES+1 cycles after start.
- mem_ack arriving in the same cycle that the timer hits its limit counts as success (ack wins).
- Timer width is 8 bits; it never wraps, because it saturates via the transition out of the WAIT state.
- err clears on the next start, not on leaving DONE.
- Q does not change outside the explicit load and read-ack cases.

Decomposition:
- Shared package cpu_pkg:
  - DATA_WIDTH default.
  - FSM state localparams: IDLE=2'd0, RD_WAIT=2'd1, WR_WAIT=2'd2, DONE=2'd3.
  - MEM_TIMEOUT default.
- One natural sub-module, mdr_wait_timer: an 8-bit counter with clear, increment and a terminal-count output, reset asynchronously by clr.

Test Plan:
- Reset and direct load:
  - Assert clr mid-cycle → Q=0 and all strobes 0 immediately.
  - Release clr, then MDRin=1, Read=0, BusMuxOut=32'hDEADBEEF → Q=32'hDEADBEEF next edge, done=0.
- Read with 3 wait cycles:
  - Q=0, start_rd pulse, mem_ack on the 3rd RD_WAIT cycle with Mdatain=32'h12345678.
  - Expect mem_rd high for 3 cycles, Q=32'h12345678, done=1 for one cycle, err=0.
- Write:
  - Q=32'hA5A5A5A5, start_wr pulse, mem_ack after 1 cycle.
  - Expect mem_wr=1 with mem_wdata=32'hA5A5A5A5 while asserted, done pulse, Q unchanged.
- Timeout:
  - TIMEOUT_CYCLES=4, start_rd, no mem_ack.
  - Expect mem_rd high exactly 4 cycles, then done=1 with err=1 and Q unchanged.
  - Then ack on the 4th cycle in a second run → err=0 and Q loaded.
- Simultaneous events:
  - start_rd and start_wr and MDRin in the same IDLE cycle → read taken, Q not directly loaded.
  - MDRin and start_wr during RD_WAIT → ignored; no write follows.
- Reset mid-read:
  - clr asserted during RD_WAIT → mem_rd drops at once, no done.
  - After release, a new start_rd completes normally.
